// File: rtl/ema_pkg.sv
// Shared definitions for the ema filter and its feeder stage.
package ema_pkg;

  // Sample width shared by the feeder and the filter.
  localparam int DATA_W = 16;

  // Q-format of the sample path: Q16.0, integer samples with no fraction bits.
  localparam int Q_INT_BITS  = 16;
  localparam int Q_FRAC_BITS = 0;

  // Feeder sequencing states.
  typedef enum logic {
    FEED_IDLE = 1'b0,
    FEED_WAIT = 1'b1
  } feed_state_e;

endpackage

// File: rtl/ema_sync_fifo.sv
// Single-clock FIFO with a registered occupancy counter and a combinational head.
// The caller must not push when full or pop when empty.
module ema_sync_fifo #(
  parameter int W     = 16,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [W-1:0]             data_i,
  output logic [W-1:0]             data_o,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [AW:0]   level_q;

  // Storage array; no reset needed since occupancy gates every read.
  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_ptr_q] <= data_i;
  end

  // Pointers wrap naturally at DEPTH; occupancy is tracked separately.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_i)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push_i, pop_i})
        2'b10:   level_q <= level_q + 1'b1;
        2'b01:   level_q <= level_q - 1'b1;
        default: level_q <= level_q;
      endcase
    end
  end

  assign data_o  = mem_q[rd_ptr_q];
  assign level_o = level_q;

endmodule

// File: rtl/ema_sample_feeder.sv
// Buffers bursty samples and hands them to the ema filter one at a time,
// strobing only while the filter is idle and waiting for its result in between.
module ema_sample_feeder #(
  parameter int DATA_W = ema_pkg::DATA_W,
  parameter int DEPTH  = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [DATA_W-1:0]        s_data_i,
  input  logic                     s_valid_i,
  output logic                     s_ready_o,
  output logic [DATA_W-1:0]        x_o,
  output logic                     valid_o,
  input  logic                     bussy_i,
  input  logic                     done_i,
  output logic [$clog2(DEPTH):0]   level_o,
  output logic                     overflow_o,
  input  logic                     clr_ovf_i
);

  import ema_pkg::*;

  localparam int LW = $clog2(DEPTH) + 1;

  feed_state_e       state_q, state_d;
  logic [LW-1:0]     level;
  logic [DATA_W-1:0] head;
  logic [DATA_W-1:0] x_q;
  logic              valid_q;
  logic              ovf_q, ovf_d;
  logic              push, pop, ovf_set;

  // Ready depends on registered occupancy only, so it never loops back to s_valid_i.
  assign s_ready_o = (level != LW'(DEPTH));
  assign push      = s_valid_i && s_ready_o;
  assign ovf_set   = s_valid_i && !s_ready_o;

  ema_sync_fifo #(
    .W     (DATA_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .pop_i   (pop),
    .data_i  (s_data_i),
    .data_o  (head),
    .level_o (level)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= FEED_IDLE;
    else      state_q <= state_d;
  end

  // Next state: IDLE leaves on a pop; WAIT leaves once the filter reports done.
  always_comb begin
    state_d = state_q;
    case (state_q)
      FEED_IDLE: if (pop)    state_d = FEED_WAIT;
      FEED_WAIT: if (done_i) state_d = FEED_IDLE;
      default:               state_d = FEED_IDLE;
    endcase
  end

  // FSM output: pop only from IDLE with data queued and the filter not busy.
  always_comb begin
    pop = 1'b0;
    if (state_q == FEED_IDLE && level != '0 && !bussy_i) pop = 1'b1;
  end

  // Sticky overflow; a new drop in the clearing cycle keeps the flag set.
  always_comb begin
    ovf_d = ovf_q;
    if (clr_ovf_i) ovf_d = 1'b0;
    if (ovf_set)   ovf_d = 1'b1;
  end

  // Output register: x_o only loads on a pop, so it is frozen throughout WAIT.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      x_q     <= '0;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      valid_q <= pop;
      ovf_q   <= ovf_d;
      if (pop) x_q <= head;
    end
  end

  assign x_o        = x_q;
  assign valid_o    = valid_q;
  assign level_o    = level;
  assign overflow_o = ovf_q;

endmodule
